uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver matching the team's 8N1 UART transmitter: same frame, same baud divider convention.
- Synchronizes the asynchronous RX line and detects the start bit.
- Samples the start bit, 8 data bits (LSB first) and the stop bit at mid-bit.
- Presents the received byte with a sticky ready flag, cleared by the consumer (command/telemetry path).

Parameters:
BAUD_DIV, 2604, baud counter reload value; one bit period = BAUD_DIV+1 clk cycles (50 MHz, matches TX).
HALF_DIV, BAUD_DIV>>1 (1302), initial count from start detection to start-bit mid-sample.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
RX  input  1  asynchronous serial line; idles high.
clr_rdy  input  1  consumer acknowledge; clears rdy.
rx_data  output  8  last received byte.
rdy  output  1  sticky: new byte valid in rx_data.
frm_err  output  1  stop bit of last byte sampled low; valid while rdy=1.
busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, sync flops=1, rx_data=8'h00, rdy=0, frm_err=0, busy=0, bit_cnt=0, baud_cnt=BAUD_DIV, shift register=0.
- Synchronizer: two flops rx_ff1 -> rx_ff2, both reset to 1. All logic uses rx_ff2 only.
- shift = (baud_cnt==0) && (state != IDLE), combinational. When shift is high, the sample is rx_ff2 in that cycle.
- States:
  - IDLE: baud_cnt held. If rx_ff2==0, go to START; load baud_cnt=HALF_DIV; clear rdy and frm_err. Call this edge t0.
  - START: baud_cnt decrements each cycle. On shift: if sample==1 (glitch/false start), go to IDLE with no output change. Otherwise go to DATA with bit_cnt=0 and baud_cnt=BAUD_DIV.
  - DATA: baud_cnt decrements. On shift: shift register = {sample, sr[7:1]}, bit_cnt+1, baud_cnt=BAUD_DIV. After the 8th data shift (bit_cnt reaches 8), go to STOP.
  - STOP: on shift, rx_data <= shift register, rdy <= 1, frm_err <= ~sample, go to IDLE.
- Sample k (0=start, 1..8=data, 9=stop) is taken in the cycle ending at edge t0+HALF_DIV+1+k*(BAUD_DIV+1). rdy is high from that edge for k=9.
- rdy clear priority: rst > rdy set on stop sample > clr_rdy. If clr_rdy and the stop sample coincide, rdy=1.
- clr_rdy when rdy=0: no effect.
- rx_data is held until the next completed frame; a false start or an aborted frame leaves it unchanged.
- A new frame overwrites rx_data even if rdy was never cleared (no overrun flag).
- busy = (state != IDLE).
- rx_ff2 already low on return to IDLE (stop sampled low / break): immediately re-enter START. A break therefore yields repeated 8'h00 frames with frm_err=1.
- rst mid-frame: all state returns to reset values at that edge; the partial byte is discarded.
- Widths: baud_cnt is 12 bits (BAUD_DIV must be < 4096); bit_cnt is 4 bits.

Test Plan:
- BAUD_DIV=15: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit 16 cycles -> rdy rises at t0+152, rx_data=8'hA5, frm_err=0, busy falls same edge.
- BAUD_DIV=2604: loop back the team UART transmitter sending 0x3C then 0xC3, pulsing clr_rdy between them -> two rdy pulses, rx_data 8'h3C then 8'hC3, frm_err=0.
- Low glitch of 4 cycles on idle RX (BAUD_DIV=15) -> START entered, sample at t0+8 reads 1, return to IDLE, rdy/rx_data unchanged.
- Frame 0x55 with stop bit driven 0 -> rdy=1, rx_data=8'h55, frm_err=1. Then RX held low -> a second frame 8'h00 with frm_err=1.
- clr_rdy asserted in the same cycle as the stop sample -> rdy=1. clr_rdy one cycle later -> rdy=0 the next edge.
- rst pulsed for 1 cycle mid-DATA (after 3 bits) -> all outputs at reset values next edge. A following full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side bundle of the 8N1 UART: serial input, consumer acknowledge and
// the received byte with its status flags.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       busy;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err,
        input  busy
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop RX synchronizer, mid-bit sampling driven by a
// down-counting baud timer, sticky ready flag cleared by the consumer.
module uart_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int HALF_DIV = BAUD_DIV >> 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [11:0] BAUD_LOAD = 12'(BAUD_DIV);
    localparam logic [11:0] HALF_LOAD = 12'(HALF_DIV);

    state_t      state_q, state_d;
    logic        rx_ff1_q, rx_ff1_d;
    logic        rx_ff2_q, rx_ff2_d;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        busy_q, busy_d;
    logic        shift;

    assign shift = (baud_cnt_q == 12'd0) && (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        rx_ff1_d   = bus.RX;
        rx_ff2_d   = rx_ff1_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        rx_data_d  = rx_data_q;
        frm_err_d  = frm_err_q;
        rdy_d      = rdy_q;

        // Consumer ack has the lowest priority; the stop sample below overrides it.
        if (bus.clr_rdy) begin
            rdy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_ff2_q) begin
                    state_d    = START;
                    baud_cnt_d = HALF_LOAD;
                    rdy_d      = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            START: begin
                if (shift) begin
                    baud_cnt_d = BAUD_LOAD;
                    if (rx_ff2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            DATA: begin
                if (shift) begin
                    sr_d       = {rx_ff2_q, sr_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = BAUD_LOAD;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            STOP: begin
                if (shift) begin
                    rx_data_d  = sr_q;
                    rdy_d      = 1'b1;
                    frm_err_d  = ~rx_ff2_q;
                    baud_cnt_d = BAUD_LOAD;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_ff1_q   <= 1'b1;
            rx_ff2_q   <= 1'b1;
            baud_cnt_q <= BAUD_LOAD;
            bit_cnt_q  <= 4'd0;
            sr_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ff1_q   <= rx_ff1_d;
            rx_ff2_q   <= rx_ff2_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;
    assign bus.busy    = busy_q;
endmodule
